// File: rtl/donkey_collision.sv
// donkey_collision: per-frame donkey/barrel collision check, lives and hit immunity.
// A frame_tick accepted in WAIT snapshots every position, then SCAN tests one barrel
// slot per cycle and RESOLVE applies at most one hit for the frame.
// Optional build macro: COLLISION_SHRINK_EN insets the donkey hitbox by 4 px on every side.
module donkey_collision #(
    parameter int BARRELS       = 10,
    parameter int DONKEY_W      = 48,
    parameter int DONKEY_H      = 64,
    parameter int BARREL_W      = 32,
    parameter int BARREL_H      = 32,
    parameter int LIVES         = 3,
    parameter int INVULN_FRAMES = 120
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start_game,
    input  logic                      animation,
    input  logic                      frame_tick,
    input  logic [10:0]               xpos,
    input  logic [10:0]               ypos,
    input  logic [BARRELS-1:0]        barrel,
    input  logic [BARRELS-1:0][10:0]  xpos_barrel,
    input  logic [BARRELS-1:0][10:0]  ypos_barrel,
    output logic                      hit,
    output logic [2:0]                lives,
    output logic                      invuln,
    output logic                      game_over
);

    localparam int IW = (BARRELS > 1) ? $clog2(BARRELS) : 1;
    localparam int CW = $clog2(INVULN_FRAMES + 1);
    localparam logic [IW-1:0] LAST_IDX  = IW'(BARRELS - 1);
    localparam logic [CW-1:0] INV_LOAD  = CW'(INVULN_FRAMES);
    localparam logic [2:0]    LIVES_RST = 3'(LIVES);
    localparam logic [11:0]   DW        = 12'(DONKEY_W);
    localparam logic [11:0]   DH        = 12'(DONKEY_H);
    localparam logic [11:0]   BW        = 12'(BARREL_W);
    localparam logic [11:0]   BH        = 12'(BARREL_H);
`ifdef COLLISION_SHRINK_EN
    localparam logic [11:0]   INSET     = 12'd4;
`else
    localparam logic [11:0]   INSET     = 12'd0;
`endif

    typedef enum logic [2:0] {IDLE, WAIT, SCAN, RESOLVE, OVER} state_t;

    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
    } pos_t;

    state_t                    state, state_nxt;
    logic [IW-1:0]             idx;
    logic [CW-1:0]             cnt;
    logic                      hit_flag;
    logic                      accept;
    logic                      do_hit;
    logic                      ovl;
    pos_t                      snap_d;
    logic [BARRELS-1:0]        snap_act;
    logic [BARRELS-1:0][10:0]  snap_xb;
    logic [BARRELS-1:0][10:0]  snap_yb;
    logic [11:0]               xd, yd, xb, yb;

    // bounding-box overlap of the donkey with the barrel slot under the scan index
    always_comb begin
        xd  = {1'b0, snap_d.x};
        yd  = {1'b0, snap_d.y};
        xb  = {1'b0, snap_xb[idx]};
        yb  = {1'b0, snap_yb[idx]};
        ovl = snap_act[idx]
              && (xd + INSET < xb + BW) && (xb < xd + DW - INSET)
              && (yd + INSET < yb + BH) && (yb < yd + DH - INSET);
    end

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // next state, tick acceptance and the hit decision for this frame
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        do_hit    = 1'b0;
        if (!start_game) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (!animation) state_nxt = WAIT;
                WAIT: begin
                    if (animation) begin
                        state_nxt = IDLE;
                    end else if (frame_tick) begin
                        accept    = 1'b1;
                        state_nxt = SCAN;
                    end
                end
                SCAN:    if (idx == LAST_IDX) state_nxt = RESOLVE;
                RESOLVE: begin
                    do_hit    = hit_flag && (cnt == '0) && (lives != 3'd0);
                    state_nxt = (do_hit && lives == 3'd1) ? OVER : WAIT;
                end
                OVER:    state_nxt = OVER;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // snapshot, scan accumulation, lives/immunity bookkeeping and outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit       <= 1'b0;
            lives     <= LIVES_RST;
            invuln    <= 1'b0;
            game_over <= 1'b0;
            cnt       <= '0;
            idx       <= '0;
            hit_flag  <= 1'b0;
            snap_d    <= '0;
            snap_act  <= '0;
            snap_xb   <= '0;
            snap_yb   <= '0;
        end else if (!start_game) begin
            hit       <= 1'b0;
            lives     <= LIVES_RST;
            invuln    <= 1'b0;
            game_over <= 1'b0;
            cnt       <= '0;
            idx       <= '0;
            hit_flag  <= 1'b0;
        end else begin
            hit <= do_hit;
            if (accept) begin
                snap_d   <= '{x: xpos, y: ypos};
                snap_act <= barrel;
                snap_xb  <= xpos_barrel;
                snap_yb  <= ypos_barrel;
                idx      <= '0;
                hit_flag <= 1'b0;
            end
            if (state == SCAN) begin
                hit_flag <= hit_flag | ovl;
                idx      <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
            end
            if (state == RESOLVE) begin
                if (do_hit) begin
                    lives  <= lives - 3'd1;
                    cnt    <= INV_LOAD;
                    invuln <= 1'b1;
                    if (lives == 3'd1) game_over <= 1'b1;
                end else if (cnt != '0) begin
                    cnt    <= cnt - 1'b1;
                    invuln <= (cnt != CW'(1));
                end
            end
        end
    end

endmodule

// File: tb/tb_donkey_collision.sv
// Directed bench for donkey_collision (default build, full hitbox).
module tb_donkey_collision;

    logic             clk = 1'b0;
    logic             rst;
    logic             start_game, animation, frame_tick;
    logic [10:0]      xpos, ypos;
    logic [9:0]       barrel;
    logic [9:0][10:0] xpos_barrel, ypos_barrel;
    logic             hit, invuln, game_over;
    logic [2:0]       lives;

    int n_chk  = 0;
    int n_fail = 0;

    donkey_collision dut (
        .clk(clk), .rst(rst), .start_game(start_game), .animation(animation),
        .frame_tick(frame_tick), .xpos(xpos), .ypos(ypos), .barrel(barrel),
        .xpos_barrel(xpos_barrel), .ypos_barrel(ypos_barrel),
        .hit(hit), .lives(lives), .invuln(invuln), .game_over(game_over)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_b(input int i, input logic act, input int x, input int y);
        barrel[i]      = act;
        xpos_barrel[i] = 11'(x);
        ypos_barrel[i] = 11'(y);
    endtask

    // drop start_game for one cycle, then let the FSM settle into WAIT
    task automatic restart();
        @(posedge clk); #1 start_game = 1'b0;
        @(posedge clk); #1 start_game = 1'b1;
        @(posedge clk); @(posedge clk); #1;
    endtask

    // tick in cycle 0, observe cycles 1..20; optional mid-frame barrel0 x move / extra tick
    task automatic run_frame(input int mid_cyc, input int mid_x, input bit mid_tick,
                             output int hcyc, output int hcnt, output bit go_hit);
        hcyc = 0; hcnt = 0; go_hit = 1'b0;
        @(posedge clk); #1 frame_tick = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            frame_tick = mid_tick && (c == mid_cyc);
            if (mid_cyc > 0 && c == mid_cyc) xpos_barrel[0] = 11'(mid_x);
            @(negedge clk);
            if (hit) begin
                if (hcnt == 0) begin
                    hcyc   = c;
                    go_hit = game_over;
                end
                hcnt++;
            end
        end
    endtask

    int hc, hn, h1, h2, h3, nh;
    bit go;

    initial begin
        rst = 1'b0; start_game = 1'b0; animation = 1'b0; frame_tick = 1'b0;
        xpos = 11'd100; ypos = 11'd100; barrel = '0; xpos_barrel = '0; ypos_barrel = '0;
        #12;
        check("rst_hit", hit, 0);
        check("rst_lives", lives, 3);
        check("rst_invuln", invuln, 0);
        check("rst_game_over", game_over, 0);
        rst = 1'b1;
        restart();

        // basic overlap: hit at tick+12, one cycle wide
        set_b(0, 1, 120, 120);
        run_frame(0, 0, 0, hc, hn, go);
        check("basic_hit_cycle", hc, 12);
        check("basic_hit_width", hn, 1);
        check("basic_lives", lives, 2);
        check("basic_invuln", invuln, 1);

        // boundary cases on a fresh game
        restart(); set_b(0, 1, 148, 100);
        run_frame(0, 0, 0, hc, hn, go);
        check("edge_x_right_nohit", hn, 0);
        check("edge_x_right_lives", lives, 3);
        restart(); set_b(0, 1, 147, 100);
        run_frame(0, 0, 0, hc, hn, go);
        check("inside_x_right_hit", hn, 1);
        restart(); set_b(0, 1, 68, 100);
        run_frame(0, 0, 0, hc, hn, go);
        check("edge_x_left_nohit", hn, 0);
        restart(); set_b(0, 1, 69, 163);
        run_frame(0, 0, 0, hc, hn, go);
        check("inside_corner_hit", hn, 1);
        restart(); set_b(0, 1, 100, 164);
        run_frame(0, 0, 0, hc, hn, go);
        check("edge_y_bottom_nohit", hn, 0);
        restart(); set_b(0, 0, 120, 120);
        run_frame(0, 0, 0, hc, hn, go);
        check("inactive_nohit", hn, 0);

        // snapshot: barrel moves onto donkey after the tick -> no hit
        restart(); set_b(0, 1, 400, 120);
        run_frame(3, 120, 0, hc, hn, go);
        check("snapshot_move_in", hn, 0);
        // snapshot: barrel moves away after the tick -> still a hit
        restart(); set_b(0, 1, 120, 120);
        run_frame(3, 400, 0, hc, hn, go);
        check("snapshot_move_out", hn, 1);
        // tick during SCAN with overlapping barrel is ignored
        restart(); set_b(0, 1, 400, 120);
        run_frame(5, 120, 1, hc, hn, go);
        check("tick_in_scan_ignored", hn, 0);

        // barrels 2,5,9 overlap the same frame -> single hit
        restart(); set_b(0, 0, 0, 0);
        set_b(2, 1, 110, 110); set_b(5, 1, 130, 140); set_b(9, 1, 90, 150);
        run_frame(0, 0, 0, hc, hn, go);
        check("multi_hit_count", hn, 1);
        check("multi_hit_cycle", hc, 12);
        check("multi_lives", lives, 2);
        set_b(2, 0, 0, 0); set_b(5, 0, 0, 0); set_b(9, 0, 0, 0);

        // overlap held: hits at frames 1, 122, 243; third hit ends the game
        restart(); set_b(0, 1, 120, 120);
        h1 = 0; h2 = 0; h3 = 0; nh = 0;
        for (int f = 1; f <= 243; f++) begin
            run_frame(0, 0, 0, hc, hn, go);
            if (hn != 0) begin
                nh++;
                if (nh == 1) h1 = f;
                else if (nh == 2) h2 = f;
                else h3 = f;
            end
            if (f == 120) check("invuln_frame120", invuln, 1);
            if (f == 121) check("invuln_frame121", invuln, 0);
            if (f == 125) check("lives_frame125", lives, 1);
        end
        check("held_hits", nh, 3);
        check("held_first", h1, 1);
        check("held_second", h2, 122);
        check("held_third", h3, 243);
        check("over_same_cycle", go, 1);
        check("over_lives", lives, 0);
        check("over_flag", game_over, 1);
        run_frame(0, 0, 0, hc, hn, go);
        run_frame(0, 0, 0, hc, nh, go);
        check("over_ignores_ticks", hn + nh, 0);
        check("over_sticky", game_over, 1);
        @(posedge clk); #1 start_game = 1'b0;
        @(posedge clk); @(negedge clk);
        check("restart_lives", lives, 3);
        check("restart_game_over", game_over, 0);
        start_game = 1'b1;

        // animation: no hits, lives and immunity retained through IDLE
        @(posedge clk); @(posedge clk); #1;
        run_frame(0, 0, 0, hc, hn, go);
        check("pre_anim_hit", hn, 1);
        animation = 1'b1;
        for (int f = 0; f < 3; f++) begin
            run_frame(0, 0, 0, hc, hn, go);
            check("anim_nohit", hn, 0);
        end
        check("anim_lives_kept", lives, 2);
        animation = 1'b0;
        @(posedge clk); @(negedge clk);
        check("anim_invuln_kept", invuln, 1);

        // async reset in the middle of a scan
        @(posedge clk); #1 frame_tick = 1'b1;
        @(posedge clk); #1 frame_tick = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b0; #1;
        check("midscan_rst_lives", lives, 3);
        check("midscan_rst_invuln", invuln, 0);
        check("midscan_rst_hit", hit, 0);
        check("midscan_rst_game_over", game_over, 0);
        @(posedge clk); #1 rst = 1'b1;
        nh = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (hit) nh++;
        end
        check("midscan_rst_no_late_hit", nh, 0);
        // first frame after reset hits normally
        run_frame(0, 0, 0, hc, hn, go);
        check("post_rst_hit_cycle", hc, 12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
